// File: rtl/tt_sweep_pkg.sv
// Shared types and default sizing for the truth-table sweep checker.
package tt_sweep_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_CHECK  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam int unsigned N_IN_DEF          = 3;
   localparam int unsigned SETTLE_CYCLES_DEF = 1;
   localparam int unsigned NVEC              = 2**N_IN_DEF;
   localparam int unsigned CNT_W             = N_IN_DEF + 1;

endpackage

// File: rtl/tt_settle_timer.sv
// Down-counter that holds each stimulus vector for LOAD_VAL cycles;
// expire_o flags the last cycle of the hold window.
module tt_settle_timer #(
   parameter int unsigned LOAD_VAL = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic load_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int unsigned W = (LOAD_VAL < 1) ? 1 : $clog2(LOAD_VAL + 1);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = W'(LOAD_VAL);
      end else if (en_i && (count_q != '0)) begin
         count_d = count_q - W'(1);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expire_o = (count_q == W'(1));

endmodule

// File: rtl/tt_sweep_checker.sv
// Sweeps all 2**N_IN input vectors through a combinational block and scores y against a golden word.
// Define TT_STOP_ON_FAIL_EN to end the sweep at the first mismatching vector.
module tt_sweep_checker
   import tt_sweep_pkg::*;
#(
   parameter int unsigned N_IN          = N_IN_DEF,
   parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [2**N_IN-1:0]   golden,
   output logic [N_IN-1:0]      dut_in,
   input  logic                 dut_out,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [N_IN:0]        err_count,
   output logic [2**N_IN-1:0]   fail_mask
);

   localparam int unsigned     VEC_N    = 2**N_IN;
   localparam logic [N_IN-1:0] LAST_VEC = N_IN'(VEC_N - 1);

   generate
      if (SETTLE_CYCLES < 1) begin : g_bad_settle
         $error("tt_sweep_checker: SETTLE_CYCLES must be >= 1");
      end
   endgenerate

   state_t            state_q, state_d;
   logic [N_IN-1:0]   vec_q, vec_d;
   logic [VEC_N-1:0]  golden_q, golden_d;
   logic [N_IN:0]     err_q, err_d;
   logic [VEC_N-1:0]  mask_q, mask_d;
   logic              pass_q, pass_d;
   logic              timer_load;
   logic              timer_expire;
   logic              mismatch;
   logic              finish;

   tt_settle_timer #(
      .LOAD_VAL (SETTLE_CYCLES)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load_i   (timer_load),
      .en_i     (state_q == ST_SETTLE),
      .expire_o (timer_expire)
   );

   assign mismatch = (dut_out != golden_q[vec_q]);

   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      state_d    = state_q;
      vec_d      = vec_q;
      golden_d   = golden_q;
      err_d      = err_q;
      mask_d     = mask_q;
      pass_d     = pass_q;
      timer_load = 1'b0;
      finish     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               golden_d   = golden;
               vec_d      = '0;
               err_d      = '0;
               mask_d     = '0;
               pass_d     = 1'b0;
               timer_load = 1'b1;
               state_d    = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (timer_expire) begin
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (mismatch) begin
               err_d         = err_q + (N_IN + 1)'(1);
               mask_d[vec_q] = 1'b1;
            end
`ifdef TT_STOP_ON_FAIL_EN
            finish = (vec_q == LAST_VEC) || mismatch;
`else
            finish = (vec_q == LAST_VEC);
`endif
            // pass is resolved here so it is already valid during the DONE pulse.
            if (finish) begin
               pass_d  = (err_d == '0);
               state_d = ST_DONE;
            end else begin
               vec_d      = vec_q + N_IN'(1);
               timer_load = 1'b1;
               state_d    = ST_SETTLE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         vec_q    <= '0;
         golden_q <= '0;
         err_q    <= '0;
         mask_q   <= '0;
         pass_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         vec_q    <= vec_d;
         golden_q <= golden_d;
         err_q    <= err_d;
         mask_q   <= mask_d;
         pass_q   <= pass_d;
      end
   end

   assign dut_in    = vec_q;
   assign busy      = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
   assign done      = (state_q == ST_DONE);
   assign pass      = pass_q;
   assign err_count = err_q;
   assign fail_mask = mask_q;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Randomized self-checking bench for tt_sweep_checker driving a y = ~b&~c | a&~b block
// with optional injected output faults; honours TT_STOP_ON_FAIL_EN.
module tb_tt_sweep_checker;
   import tt_sweep_pkg::*;

   localparam int unsigned S   = SETTLE_CYCLES_DEF;
   localparam int unsigned PER = S + 1;

   logic                clk;
   logic                reset;
   logic                start;
   logic [NVEC-1:0]     golden;
   logic [N_IN_DEF-1:0] dut_in;
   logic                dut_out;
   logic                busy;
   logic                done;
   logic                pass;
   logic [CNT_W-1:0]    err_count;
   logic [NVEC-1:0]     fail_mask;
   logic [NVEC-1:0]     flip;

   int n_tests = 0;
   int n_fail  = 0;

   tt_sweep_checker #(
      .N_IN          (N_IN_DEF),
      .SETTLE_CYCLES (S)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .golden    (golden),
      .dut_in    (dut_in),
      .dut_out   (dut_out),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .err_count (err_count),
      .fail_mask (fail_mask)
   );

   function automatic logic fn_y(input logic [N_IN_DEF-1:0] v);
      logic a, b, c;
      a = v[2];
      b = v[1];
      c = v[0];
      return (~b & ~c) | (a & ~b);
   endfunction

   // Function block under test, with per-vector fault injection.
   assign dut_out = fn_y(dut_in) ^ flip[dut_in];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, " busy"}, 32'(busy), 0);
      check({tag, " done"}, 32'(done), 0);
      check({tag, " pass"}, 32'(pass), 0);
      check({tag, " err"}, 32'(err_count), 0);
      check({tag, " mask"}, 32'(fail_mask), 0);
      check({tag, " dut_in"}, 32'(dut_in), 0);
   endtask

   // Runs one sweep; restart_at (1..done cycle) re-asserts start during that cycle.
   task automatic run_sweep(input string tag, input logic [NVEC-1:0] g,
                            input logic [NVEC-1:0] fl, input int restart_at);
      logic [NVEC-1:0] truth, mm, exp_mask;
      int exp_err, last_vec, done_cyc, first_bad;

      for (int i = 0; i < NVEC; i++) truth[i] = fn_y(N_IN_DEF'(i));
      mm = g ^ truth ^ fl;
`ifdef TT_STOP_ON_FAIL_EN
      first_bad = -1;
      for (int i = NVEC - 1; i >= 0; i--) if (mm[i]) first_bad = i;
      if (first_bad >= 0) begin
         exp_mask = '0;
         exp_mask[first_bad] = 1'b1;
         exp_err  = 1;
         last_vec = first_bad;
      end else begin
         exp_mask = '0;
         exp_err  = 0;
         last_vec = NVEC - 1;
      end
`else
      first_bad = 0;
      exp_mask  = mm;
      exp_err   = $countones(mm);
      last_vec  = NVEC - 1;
`endif
      done_cyc = (last_vec + 1) * PER + 1;

      @(negedge clk);
      golden = g;
      flip   = fl;
      start  = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= done_cyc + 2; c++) begin
         @(negedge clk);
         start  = (c == restart_at) && (c <= done_cyc);
         golden = NVEC'($urandom);
         if (c < done_cyc) begin
            check({tag, " busy"}, 32'(busy), 1);
            check({tag, " done"}, 32'(done), 0);
            check({tag, " pass_cleared"}, 32'(pass), 0);
            check({tag, " dut_in"}, 32'(dut_in), 32'((c - 1) / PER));
         end else begin
            check({tag, c == done_cyc ? " done_pulse" : " done_low"}, 32'(done),
                  (c == done_cyc) ? 1 : 0);
            check({tag, " busy_end"}, 32'(busy), 0);
            check({tag, " pass"}, 32'(pass), (exp_err == 0) ? 1 : 0);
            check({tag, " err_count"}, 32'(err_count), 32'(exp_err));
            check({tag, " fail_mask"}, 32'(fail_mask), 32'(exp_mask));
            check({tag, " dut_in_hold"}, 32'(dut_in), 32'(last_vec));
         end
      end
      start = 1'b0;
   endtask

   initial begin
      reset  = 1'b1;
      start  = 1'b0;
      golden = '0;
      flip   = '0;
      #12;
      check_idle_zero("reset");
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_idle_zero("post_reset");

      run_sweep("all_pass",   8'h31, 8'h00, 0);
      run_sweep("one_fail",   8'h33, 8'h00, 0);
      run_sweep("all_fail",   8'hCE, 8'h00, 0);
      run_sweep("restart_5",  8'h31, 8'h00, 5);
      run_sweep("start_done", 8'h31, 8'h00, NVEC * PER + 1);
      run_sweep("fault_vec7", 8'h31, 8'h80, 0);

      // Async reset in cycle 6 of a failing sweep, then a clean sweep.
      @(negedge clk);
      golden = 8'hCE;
      start  = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      check("pre_reset err", 32'(err_count != 0), 1);
      #2 reset = 1'b1;
      #1;
      check_idle_zero("async_reset");
      @(negedge clk);
      reset = 1'b0;
      run_sweep("after_reset", 8'h31, 8'h00, 0);

      for (int r = 0; r < 8; r++) begin
         logic [NVEC-1:0] g, fl;
         int rs;
         g  = NVEC'($urandom);
         fl = ($urandom_range(0, 1) == 1) ? NVEC'($urandom) : '0;
         rs = $urandom_range(0, 20);
         run_sweep($sformatf("rand%0d", r), g, fl, rs);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
